paddle_motion: RTL

//  Consumer side of the up/down/stay paddle-command interface. Any controller
//  (neural AI player or human button decoder) drives this block's command inputs.

---
 rtl/pong_pkg.sv | 39 +++
 rtl/paddle_motion_if.sv | 25 ++
 rtl/vel_ramp.sv | 67 ++++++
 rtl/paddle_motion.sv | 82 ++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong geometry, paddle dynamics constants,
// FSM state encoding and the paddle command encoding.
package pong_pkg;

  localparam int W        = 13;
  localparam int Y_TOP    = 0;
  localparam int Y_BOTTOM = 1920;
  localparam int PADDLE_H = 320;
  localparam int Y_INIT   = 800;
  localparam int V_MAX    = 48;
  localparam int ACCEL    = 4;
  localparam int DECEL    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_BRAKE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DOWN = 2'd2
  } cmd_e;

  // up and down together cancel; stay simply yields no motion.
  function automatic cmd_e decode_cmd(
    input logic up,
    input logic down
  );
    cmd_e c;
    c = CMD_NONE;
    if (up && !down) c = CMD_UP;
    if (down && !up) c = CMD_DOWN;
    return c;
  endfunction

endpackage

// File: rtl/paddle_motion_if.sv
// Paddle command/status bundle between a controller
// (AI or button decoder) and the paddle integrator.
interface paddle_motion_if #(
  parameter int W = 13
);
  logic                frame_tick;
  logic                freeze;
  logic                up;
  logic                down;
  logic                stay;
  logic [W-1:0]        p_y;
  logic signed [7:0]   vel;
  logic                moving;
  logic                wall_hit;

  modport master (
    output frame_tick, freeze, up, down, stay,
    input  p_y, vel, moving, wall_hit
  );

  modport slave (
    input  frame_tick, freeze, up, down, stay,
    output p_y, vel, moving, wall_hit
  );
endinterface

// File: rtl/vel_ramp.sv
// Combinational velocity ramp: next state and
// next velocity from current state, velocity, dir.
module vel_ramp
  import pong_pkg::*;
#(
  parameter logic [7:0] V_MAX_P = 8'(V_MAX),
  parameter logic [7:0] ACCEL_P = 8'(ACCEL),
  parameter logic [7:0] DECEL_P = 8'(DECEL)
) (
  input  state_e            state_i,
  input  logic signed [7:0] vel_i,
  input  cmd_e              dir_i,
  output state_e            state_o,
  output logic signed [7:0] vel_o
);

  logic       neg;
  logic [7:0] mag;
  logic [7:0] mag_up;
  logic [7:0] mag_dn;
  logic [7:0] mag_nx;
  cmd_e       sgn;

  // Work on |vel| and re-apply the sign; braking never flips it.
  always_comb begin
    neg     = vel_i[7];
    mag     = neg ? 8'(-vel_i) : 8'(vel_i);
    sgn     = (mag == 8'd0) ? CMD_NONE :
              (neg ? CMD_UP : CMD_DOWN);
    mag_up  = (mag + ACCEL_P >= V_MAX_P) ?
              V_MAX_P : mag + ACCEL_P;
    mag_dn  = (mag > DECEL_P) ?
              mag - DECEL_P : 8'd0;
    mag_nx  = mag;
    state_o = state_i;
    vel_o   = vel_i;
    unique case (state_i)
      ST_IDLE: begin
        if (dir_i == CMD_UP) begin
          state_o = ST_ACCEL;
          vel_o   = -$signed(ACCEL_P);
        end else if (dir_i == CMD_DOWN) begin
          state_o = ST_ACCEL;
          vel_o   = $signed(ACCEL_P);
        end
      end
      ST_ACCEL, ST_CRUISE: begin
        if (dir_i == sgn && sgn != CMD_NONE) begin
          mag_nx  = mag_up;
          state_o = (mag_up == V_MAX_P) ?
                    ST_CRUISE : ST_ACCEL;
        end else begin
          mag_nx  = mag_dn;
          state_o = (mag_dn == 8'd0) ?
                    ST_IDLE : ST_BRAKE;
        end
        vel_o = neg ? -$signed(mag_nx) : $signed(mag_nx);
      end
      ST_BRAKE: begin
        mag_nx  = mag_dn;
        state_o = (mag_dn == 8'd0) ? ST_IDLE : ST_BRAKE;
        vel_o   = neg ? -$signed(mag_nx) : $signed(mag_nx);
      end
    endcase
  end

endmodule

// File: rtl/paddle_motion.sv
// Paddle integrator: per-frame velocity/position
// update with playfield clamp and wall_hit pulse.
module paddle_motion
  import pong_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  paddle_motion_if.slave  pif
);

  localparam logic signed [W+1:0] LIM_LO =
    (W+2)'(Y_TOP);
  localparam logic signed [W+1:0] LIM_HI =
    (W+2)'(Y_BOTTOM - PADDLE_H);

  logic [W-1:0]        p_y_q, p_y_d;
  logic signed [7:0]   vel_q, vel_d;
  state_e              state_q, state_d;
  logic                wall_hit_q, wall_hit_d;

  logic                upd;
  cmd_e                dir;
  state_e              st_nx;
  logic signed [7:0]   vel_nx;
  logic signed [W+1:0] sum;
  logic                unused_stay;

  assign unused_stay = pif.stay;
  assign upd = pif.frame_tick & ~pif.freeze;
  assign dir = decode_cmd(pif.up, pif.down);

  vel_ramp u_ramp (
    .state_i (state_q),
    .vel_i   (vel_q),
    .dir_i   (dir),
    .state_o (st_nx),
    .vel_o   (vel_nx)
  );

  // Integrate position; a clamp overrides the ramp result.
  always_comb begin
    sum        = $signed({2'b00, p_y_q}) +
                 $signed({{(W-6){vel_nx[7]}}, vel_nx});
    p_y_d      = p_y_q;
    vel_d      = vel_q;
    state_d    = state_q;
    wall_hit_d = 1'b0;
    if (upd) begin
      p_y_d   = sum[W-1:0];
      vel_d   = vel_nx;
      state_d = st_nx;
      if (sum < LIM_LO || sum > LIM_HI) begin
        p_y_d      = (sum < LIM_LO) ?
                     LIM_LO[W-1:0] : LIM_HI[W-1:0];
        vel_d      = 8'sd0;
        state_d    = ST_IDLE;
        wall_hit_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_y_q      <= W'(Y_INIT);
      vel_q      <= 8'sd0;
      state_q    <= ST_IDLE;
      wall_hit_q <= 1'b0;
    end else begin
      p_y_q      <= p_y_d;
      vel_q      <= vel_d;
      state_q    <= state_d;
      wall_hit_q <= wall_hit_d;
    end
  end

  assign pif.p_y      = p_y_q;
  assign pif.vel      = vel_q;
  assign pif.moving   = (state_q != ST_IDLE);
  assign pif.wall_hit = wall_hit_q;

endmodule
